// File: rtl/display_scan_driver_pkg.sv
// Shared constants for the multiplexed hex display scanner: digit count,
// nibble width, default prescale and the scan index type.
package display_scan_driver_pkg;
  localparam int NUM_DIGITS       = 4;
  localparam int NIBBLE_W         = 4;
  localparam int DATA_W           = NUM_DIGITS * NIBBLE_W;
  localparam int IDX_W            = $clog2(NUM_DIGITS);
  localparam int TICK_DIV_DEFAULT = 1000;

  typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/scan_tick_gen.sv
// Prescaler: free-running 0..TICK_DIV-1 counter, tick is combinational on the
// terminal count (same cycle); no backpressure, never stalls.
module scan_tick_gen
  import display_scan_driver_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic clr,
  output logic tick
);
  localparam int                CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/display_scan_driver.sv
// Four-digit hex scan driver: double-buffered display data swapped only at frame wrap; outputs
// decode registered state (zero latency), no backpressure. Optional DISPLAY_SCAN_LZB_EN enables leading-zero blanking.
module display_scan_driver
  import display_scan_driver_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  load,
  input  logic [DATA_W-1:0]     data,
  output logic [NIBBLE_W-1:0]   nibble,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  blank,
  output logic                  frame
);
  localparam idx_t IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic              tick;
  logic              wrap;
  idx_t              idx_q, idx_d;
  logic [DATA_W-1:0] disp_q, disp_d;
  logic [DATA_W-1:0] pend_dat_q, pend_dat_d;
  logic              pend_q, pend_d;
  logic              frame_q, frame_d;
  logic [NUM_DIGITS-1:0] onehot;

  scan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .clr  (clr),
    .tick (tick)
  );

  assign wrap = tick && (idx_q == IDX_LAST);

  // A load on the wrap cycle goes straight to the display register.
  always_comb begin
    idx_d      = idx_q;
    disp_d     = disp_q;
    pend_dat_d = pend_dat_q;
    pend_d     = pend_q;
    frame_d    = wrap;
    if (tick) idx_d = idx_q + 1'b1;
    if (load) begin
      pend_dat_d = data;
      pend_d     = 1'b1;
    end
    if (wrap) begin
      if (load)        disp_d = data;
      else if (pend_q) disp_d = pend_dat_q;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      idx_q      <= '0;
      disp_q     <= '0;
      pend_dat_q <= '0;
      pend_q     <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      pend_dat_q <= pend_dat_d;
      pend_q     <= pend_d;
      frame_q    <= frame_d;
    end
  end

  assign nibble = disp_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign onehot = NUM_DIGITS'(1) << idx_q;
  assign frame  = frame_q;

`ifdef DISPLAY_SCAN_LZB_EN
  // Digit k is a leading zero when it and every digit above it are zero.
  logic [NUM_DIGITS-1:0] lz;
  always_comb begin
    lz = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      lz[k] = ((disp_q >> (k * NIBBLE_W)) == '0);
    end
  end
  assign blank    = lz[idx_q];
  assign digit_en = blank ? '0 : onehot;
`else
  assign blank    = 1'b0;
  assign digit_en = onehot;
`endif
endmodule
